fp16_add_arbiter: RTL and testbench
===================================

# fp16_add_arbiter

Round-robin arbiter that shares one external FP16 adder among `NUM_REQ` requesters in the NPU datapath. It accepts operand pairs over per-requester valid/ready handshakes and issues one pair per cycle to the adder. It tracks each in-flight operation with a requester tag through the adder's fixed latency and returns each sum to the requester that issued it. Each requester may have at most one operation outstanding.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; allowed range 2..8.
- `ADD_LAT`, 2: adder latency in cycles from `add_valid` to a valid `add_result`; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in `NUM_REQ`: requester i has an operand pair ready.
- `req_a` in `16*NUM_REQ`: operand A, FP16; slice i is bits [16i+15:16i].
- `req_b` in `16*NUM_REQ`: operand B, FP16; same slicing as `req_a`.
- `req_ready` out `NUM_REQ`: grant; at most one bit is high per cycle.
- `rsp_valid` out `NUM_REQ`: one-cycle pulse carrying requester i's result.
- `rsp_result` out 16: sum; shared by all requesters and qualified by `rsp_valid`.
- `add_valid` out 1: issue strobe to the adder.
- `add_a`, `add_b` out 16 each: registered operands to the adder.
- `add_result` in 16: adder output, sampled exactly `ADD_LAT` cycles after `add_valid`.
- `busy` out 1: at least one operation is pending.

## Operation

- **Eligibility:** `elig[i] = req_valid[i] & ~pending[i]`.
- **Grant:**
  - Round-robin. The search starts at `rr_ptr` and wraps modulo `NUM_REQ`.
  - `req_ready` is combinational from `elig` and `rr_ptr`, and is one-hot or zero.
  - A handshake occurs on requester i when `req_valid[i] & req_ready[i]`.
- **On a handshake to requester g:**
  - Register `add_a`/`add_b` from slice g.
  - Set `add_valid` to 1 for the next cycle.
  - Set `pending[g]`.
  - Push tag g with valid=1 into the tag pipeline.
  - Set `rr_ptr` to (g+1) mod `NUM_REQ`.
- **No handshake:** `add_valid` is 0, `add_a`/`add_b` hold their values, and `rr_ptr` holds.
- **Tag pipeline:**
  - Depth `ADD_LAT`, with entries `{valid, tag[$clog2(NUM_REQ)-1:0]}`.
  - It advances every cycle and is aligned so the tail matches `add_result`.
- **Retire:** when the tail is valid with tag t:
  - Register `rsp_result <= add_result`.
  - Set `rsp_valid[t]` to 1 for exactly one cycle.
  - Clear `pending[t]` on the same edge.
- **Response path:** there is no response backpressure. A requester must accept whenever `rsp_valid` is high.
- **Same-cycle retire and re-request:** requester i may be granted again in the cycle its `rsp_valid[i]` is high.
- **Simultaneous events:** a retire for one requester and a grant to another in the same cycle are independent.
- **Concurrency limit:** at most `NUM_REQ` operations are in flight; one per requester.
- **Reset (asynchronous, any time):**
  - `pending`, the tag-pipeline valid bits, `add_valid`, `rsp_valid` and `busy` go to 0.
  - `add_a`, `add_b`, `rsp_result` go to 16'h0000; `rr_ptr` goes to 0.
  - In-flight results returning after reset are discarded, because their tags are invalid.
- **Arithmetic:** the block is pure transport and does not inspect or modify FP16 values.

## Timing

- Handshake at cycle T → `add_valid` high at T+1 → `add_result` sampled at T+1+`ADD_LAT` → `rsp_valid` high at T+2+`ADD_LAT`. With `ADD_LAT`=2 the latency is 4 cycles.
- Throughput is one issue per cycle. A single requester achieves at most one operation per `ADD_LAT`+2 cycles.
- `req_ready` depends combinationally on `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- All outputs except `req_ready` are registered; `busy` = `|pending` is registered.
- **Fairness:** a continuously eligible requester is granted within `NUM_REQ` cycles.

## Structure

- **Shared package `npu_fp_pkg`:**
  - `FP16_W` = 16.
  - FP16 constants `FP16_ZERO` = 16'h0000, `FP16_ONE` = 16'h3C00.
  - Function `req_slice(i)`, returning the bit offset 16*i.
- **Sub-module `rr_arbiter #(N)`:**
  - Inputs `req[N]` and `ptr`.
  - Outputs `gnt[N]` (one-hot or zero) and `gnt_idx`.
  - Combinational, reusable for other shared NPU units.
- **Top level holds:** `pending`, `rr_ptr`, the issue registers, the tag shift register and the response registers.

## Test plan

The bench uses a behavioural adder model with `ADD_LAT`=2.

1. **Single request:** requester 0 sends a=16'h3C00, b=16'h3C00 at cycle 5 → `add_valid` at 6, `rsp_valid[0]` at 9 with `rsp_result`=16'h4000; `busy` falls at 10.
2. **All-requester contention:** all 4 raise `req_valid` at cycle 0 after reset → grants 0,1,2,3 in cycles 0–3. `rsp_valid` pulses for 0,1,2,3 in cycles 4–7, each with the correct sum (for example 16'h4000+16'hC000=16'h0000 on requester 2).
3. **Outstanding limit:** requester 1 holds `req_valid` continuously → `req_ready[1]` is low while pending and re-grants in the same cycle `rsp_valid[1]` is high (one op every 4 cycles).
4. **Round-robin wrap:** `rr_ptr`=3 with requesters 0 and 3 eligible → grant 3, then 0; the pointer wraps to 0, then 1.
5. **Reset mid-flight:** `rst` pulses 1 cycle after two issues → all outputs reach their reset values immediately, no `rsp_valid` occurs for the flushed ops, and a new request after reset completes normally.
6. **Randomised back-to-back traffic (1000 ops):** scoreboard checks that every response matches the model's sum and requester, with no duplicates or losses.

Source files
------------

// File: rtl/npu_fp_pkg.sv
// Shared FP16 definitions for NPU datapath units that move or share FP16 operands.
package npu_fp_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  // Bit offset of requester i's operand inside a flattened operand bus.
  function automatic int req_slice(input int i);
    return FP16_W * i;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt == '0 && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gnt_idx                  = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fp16_add_arbiter.sv
// Shares one fixed-latency FP16 adder among NUM_REQ requesters, routing each sum
// back to its issuer via a tag pipeline aligned with the adder latency.
module fp16_add_arbiter
  import npu_fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_result,
  output logic                  add_valid,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  input  logic [15:0]           add_result,
  output logic                  busy
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        pending, elig, gnt, retire;
  logic [IW-1:0]             gnt_idx, rr_ptr;
  logic                      hs;
  // Stage 0 is the issue stage (add_valid); stage ADD_LAT lines up with add_result.
  logic [ADD_LAT:0]          vld_pipe;
  logic [ADD_LAT:0][IW-1:0]  tag_pipe;

  assign elig = req_valid & ~pending;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);
  assign add_valid = vld_pipe[0];

  always_comb begin
    retire = '0;
    if (vld_pipe[ADD_LAT]) retire[tag_pipe[ADD_LAT]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      rr_ptr     <= '0;
      vld_pipe   <= '0;
      tag_pipe   <= '0;
      add_a      <= FP16_ZERO;
      add_b      <= FP16_ZERO;
      rsp_valid  <= '0;
      rsp_result <= FP16_ZERO;
      busy       <= 1'b0;
    end else begin
      vld_pipe[0] <= hs;
      if (hs) begin
        tag_pipe[0] <= gnt_idx;
        add_a       <= req_a[req_slice(int'(gnt_idx)) +: FP16_W];
        add_b       <= req_b[req_slice(int'(gnt_idx)) +: FP16_W];
        rr_ptr      <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
      for (int k = 1; k <= ADD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
      rsp_valid <= retire;
      if (vld_pipe[ADD_LAT]) rsp_result <= add_result;
      // A retiring requester is never granted in the same cycle, so the order is safe.
      pending <= (pending & ~retire) | (hs ? gnt : '0);
      busy    <= |pending;
    end
  end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed and randomised bench for fp16_add_arbiter with a 2-cycle behavioural adder.
module tb_fp16_add_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [15:0]     rsp_result, add_a, add_b, add_result;
  logic            add_valid, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp16_add_arbiter #(.NUM_REQ(N), .ADD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .add_valid  (add_valid),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .busy       (busy)
  );

  // Exact FP16 encodings of the small integers used as operands and sums.
  function automatic int h2i(input logic [15:0] h);
    case (h)
      16'h0000: return 0;   16'h3C00: return 1;   16'h4000: return 2;
      16'h4200: return 3;   16'h4400: return 4;   16'h4500: return 5;
      16'h4600: return 6;   16'h4700: return 7;   16'h4800: return 8;
      16'h4880: return 9;   16'h4900: return 10;  16'hBC00: return -1;
      16'hC000: return -2;  16'hC200: return -3;  16'hC400: return -4;
      default:  return 1000;
    endcase
  endfunction

  function automatic logic [15:0] i2h(input int v);
    case (v)
      0: return 16'h0000;   1: return 16'h3C00;   2: return 16'h4000;
      3: return 16'h4200;   4: return 16'h4400;   5: return 16'h4500;
      6: return 16'h4600;   7: return 16'h4700;   8: return 16'h4800;
      9: return 16'h4880;  10: return 16'h4900;  -1: return 16'hBC00;
      -2: return 16'hC000; -3: return 16'hC200;  -4: return 16'hC400;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    return i2h(h2i(a) + h2i(b));
  endfunction

  // External adder: not reset, so flushed operations still come back after a reset.
  logic [15:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= add_valid ? fadd(add_a, add_b) : 16'hDEAD;
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_result = apipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
  } vec_t;

  vec_t        vt [7];
  vec_t        ct [4];
  logic [15:0] ops [8];

  bit          outst [N];
  logic [15:0] exp_sum [N];
  int          waitc [N];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 16'h3C00, 16'h3C00, 16'h4000};
    vt[1] = '{1, 16'h4000, 16'hC000, 16'h0000};
    vt[2] = '{2, 16'h4200, 16'h3C00, 16'h4400};
    vt[3] = '{3, 16'h4400, 16'h4500, 16'h4880};
    vt[4] = '{1, 16'hBC00, 16'hC000, 16'hC200};
    vt[5] = '{3, 16'h0000, 16'h4700, 16'h4700};
    vt[6] = '{2, 16'h4500, 16'h4500, 16'h4900};
    ct[0] = '{0, 16'h3C00, 16'h3C00, 16'h4000};
    ct[1] = '{1, 16'h3C00, 16'h4000, 16'h4200};
    ct[2] = '{2, 16'h4000, 16'hC000, 16'h0000};
    ct[3] = '{3, 16'h4200, 16'h4400, 16'h4700};
    ops   = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200,
              16'h4400, 16'h4500, 16'hBC00, 16'hC000};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rst       = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset add_valid", add_valid, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset add_a", add_a, 0);
    chk("reset add_b", add_b, 0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset req_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Isolated requests: the first one issues at cycle 5 after reset.
    repeat (5) next();
    for (int v = 0; v < 7; v++) begin
      set_req(vt[v].id, vt[v].a, vt[v].b);
      @(negedge clk);
      chk("single grant", req_ready, 32'(1) << vt[v].id);
      next();
      req_valid = '0;
      @(negedge clk);
      chk("single add_valid", add_valid, 1);
      chk("single add_a", add_a, vt[v].a);
      chk("single add_b", add_b, vt[v].b);
      next();
      @(negedge clk);
      chk("single add_valid drop", add_valid, 0);
      chk("single busy", busy, 1);
      next();
      @(negedge clk);
      chk("single rsp early", rsp_valid, 0);
      next();
      @(negedge clk);
      chk("single rsp_valid", rsp_valid, 32'(1) << vt[v].id);
      chk("single rsp_result", rsp_result, vt[v].sum);
      next();
      @(negedge clk);
      chk("single rsp pulse", rsp_valid, 0);
      chk("single busy fall", busy, 0);
      next();
    end

    // All requesters contend right after reset.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, ct[i].a, ct[i].b);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("contend ready", req_ready, (c < 4) ? (32'(1) << c) : 0);
      chk("contend rsp_valid", rsp_valid, (c >= 4 && c < 8) ? (32'(1) << (c - 4)) : 0);
      if (c >= 4 && c < 8) chk("contend rsp_result", rsp_result, ct[c-4].sum);
      next();
      if (c < 4) req_valid[c] = 1'b0;
    end

    // Requester 1 holds valid: blocked while pending, re-granted on its response cycle.
    set_req(1, 16'h3C00, 16'h4000);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk("limit ready", req_ready, (c % 4 == 0) ? 2 : 0);
      chk("limit rsp_valid", rsp_valid, (c >= 4 && c % 4 == 0) ? 2 : 0);
      if (c >= 4 && c % 4 == 0) chk("limit rsp_result", rsp_result, 16'h4200);
      next();
    end
    req_valid = '0;
    repeat (6) next();

    // Pointer is 2: grant 2 moves it to 3, then 3 and 0 compete across the wrap.
    set_req(2, 16'h3C00, 16'h3C00);
    @(negedge clk);
    chk("rr grant2", req_ready, 4);
    next();
    req_valid = '0;
    set_req(0, 16'h3C00, 16'h3C00);
    set_req(3, 16'h3C00, 16'h3C00);
    @(negedge clk);
    chk("rr wrap grant3", req_ready, 8);
    next();
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk("rr wrap grant0", req_ready, 1);
    next();
    req_valid = '0;
    repeat (6) next();
    set_req(0, 16'h3C00, 16'h3C00);
    set_req(1, 16'h3C00, 16'h3C00);
    set_req(3, 16'h3C00, 16'h3C00);
    @(negedge clk);
    chk("rr ptr at 1", req_ready, 2);
    next();
    req_valid = '0;
    set_req(0, 16'h3C00, 16'h3C00);
    set_req(3, 16'h3C00, 16'h3C00);
    @(negedge clk);
    chk("rr ptr at 2", req_ready, 8);
    next();
    req_valid = '0;
    repeat (6) next();

    // Reset while two operations are in the adder.
    do_reset();
    set_req(0, 16'h3C00, 16'h3C00);
    @(negedge clk);
    next();
    req_valid = '0;
    set_req(1, 16'h4000, 16'h4000);
    @(negedge clk);
    next();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("midrst add_valid", add_valid, 0);
    chk("midrst rsp_valid", rsp_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst add_a", add_a, 0);
    chk("midrst add_b", add_b, 0);
    chk("midrst rsp_result", rsp_result, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flushed rsp_valid", rsp_valid, 0);
      chk("flushed busy", busy, 0);
      next();
    end
    set_req(2, 16'h4000, 16'h4000);
    @(negedge clk);
    chk("post-reset grant", req_ready, 4);
    next();
    req_valid = '0;
    repeat (3) next();
    @(negedge clk);
    chk("post-reset rsp_valid", rsp_valid, 4);
    chk("post-reset rsp_result", rsp_result, 16'h4400);
    next();

    // Random back-to-back traffic against a per-requester scoreboard.
    do_reset();
    begin
      int raised = 0;
      int done   = 0;
      int cyc    = 0;
      for (int i = 0; i < N; i++) begin
        outst[i] = 1'b0;
        waitc[i] = 0;
      end
      while (done < 1000 && cyc < 20000) begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && outst[i]) req_valid[i] = 1'b0;
          if (!req_valid[i] && !outst[i] && raised < 1000 && $urandom_range(3) != 0) begin
            set_req(i, ops[$urandom_range(7)], ops[$urandom_range(7)]);
            waitc[i] = 0;
            raised++;
          end
        end
        @(negedge clk);
        if (rsp_valid != '0) begin
          chk("rand rsp onehot", 32'($onehot(rsp_valid)), 1);
          for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) begin
              chk("rand rsp expected", 32'(outst[i]), 1);
              chk("rand rsp_result", rsp_result, exp_sum[i]);
              outst[i] = 1'b0;
              done++;
            end
          end
        end
        chk("rand ready onehot0", 32'($onehot0(req_ready)), 1);
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            chk("rand fairness", 32'(waitc[i] < N), 1);
            outst[i]   = 1'b1;
            exp_sum[i] = fadd(req_a[i*16 +: 16], req_b[i*16 +: 16]);
          end else if (req_valid[i]) begin
            waitc[i]++;
          end
        end
        next();
        cyc++;
      end
      chk("rand completed", done, 1000);
      for (int i = 0; i < N; i++) chk("rand no loss", 32'(outst[i]), 0);
    end
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
